// File: rtl/h14rx_tmds_align_decode.sv
// Receive-side TMDS channel: hunts for the word boundary using runs of control tokens,
// then decodes 8b data / 2b control. Streaming, one word in and one word out per clock.
module h14rx_tmds_align_decode #(
  parameter int LockCount     = 12,
  parameter int SearchTimeout = 4096,
  parameter int LossTimeout   = 8192
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic [9:0] tmds_word,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] bit_offset,
  output logic       fsm_state
);

  localparam int TmoMax = (SearchTimeout > LossTimeout) ? SearchTimeout : LossTimeout;
  localparam int TmoW   = $clog2(TmoMax);
  localparam int RunW   = $clog2(LockCount + 1);
  localparam logic [TmoW-1:0] SearchLast = TmoW'(SearchTimeout - 1);
  localparam logic [TmoW-1:0] LossLast   = TmoW'(LossTimeout - 1);
  localparam logic [RunW-1:0] RunFull    = RunW'(LockCount);

  typedef enum logic {S_SEARCH = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [9:0]      w0_q, w1_q;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [RunW-1:0] run_q, run_d, run_inc;
  logic [3:0]      off_q, off_d, off_next;
  logic [7:0]      data_q, data_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic            de_q, de_d;

  logic [19:0] window;
  logic [9:0]  aligned;
  logic        is_ctrl;
  logic [1:0]  token;
  logic [7:0]  qv, dec;
  logic        lock_now;

  // w1 is the older word, so the window is in serial order from bit 0 upward.
  assign window  = {w0_q, w1_q};
  assign aligned = 10'(window >> off_q);

  always_comb begin
    is_ctrl = 1'b1;
    token   = 2'b00;
    case (aligned)
      10'h354: token = 2'b00;
      10'h0AB: token = 2'b01;
      10'h154: token = 2'b10;
      10'h2AB: token = 2'b11;
      default: is_ctrl = 1'b0;
    endcase
  end

  always_comb begin
    qv     = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    dec    = '0;
    dec[0] = qv[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = aligned[8] ? (qv[i] ^ qv[i-1]) : ~(qv[i] ^ qv[i-1]);
    end
  end

  assign lock_now = (state_q == S_LOCKED);

  always_comb begin
    off_next = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
    run_inc  = (run_q == RunFull) ? run_q : run_q + RunW'(1);
    state_d  = state_q;
    run_d    = run_q;
    tmo_d    = tmo_q;
    off_d    = off_q;
    case (state_q)
      S_SEARCH: begin
        run_d = is_ctrl ? run_inc : '0;
        tmo_d = tmo_q + TmoW'(1);
        // Lock takes priority over a slip on the same edge.
        if (run_d == RunFull) begin
          state_d = S_LOCKED;
          run_d   = '0;
          tmo_d   = '0;
        end else if (tmo_q == SearchLast) begin
          off_d = off_next;
          run_d = '0;
          tmo_d = '0;
        end
      end
      S_LOCKED: begin
        run_d = '0;
        if (is_ctrl) begin
          tmo_d = '0;
        end else if (tmo_q == LossLast) begin
          state_d = S_SEARCH;
          off_d   = off_next;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: state_d = S_SEARCH;
    endcase
  end

  always_comb begin
    data_d = 8'h00;
    ctrl_d = 2'b00;
    de_d   = 1'b0;
    if (lock_now) begin
      if (is_ctrl) begin
        ctrl_d = token;
      end else begin
        de_d   = 1'b1;
        data_d = dec;
        ctrl_d = ctrl_q;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q <= S_SEARCH;
      w0_q    <= '0;
      w1_q    <= '0;
      tmo_q   <= '0;
      run_q   <= '0;
      off_q   <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
      de_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w0_q    <= tmds_word;
      w1_q    <= w0_q;
      tmo_q   <= tmo_d;
      run_q   <= run_d;
      off_q   <= off_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      de_q    <= de_d;
    end
  end

  assign data       = data_q;
  assign ctrl       = ctrl_q;
  assign de         = de_q;
  assign locked     = lock_now;
  assign bit_offset = off_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_h14rx_tmds_align_decode.sv
// Bench for h14rx_tmds_align_decode: a reference TMDS encoder feeds a bit-rotated stream,
// and a queue of expected {de,ctrl,data} entries is compared two cycles later.
module tb_h14rx_tmds_align_decode;
  localparam int LC   = 12;
  localparam int ST   = 256;
  localparam int LT   = 512;
  localparam int LINE = 200;
  localparam int HBL  = 40;

  logic       pixel_clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] tmds_word = '0;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic [3:0] bit_offset;
  logic       fsm_state;

  int checks = 0;
  int errors = 0;
  int rot = 0;
  int enc_cnt = 0;
  int cyc = 0;
  int lock_cyc = -1;
  int drop_cyc = -1;
  logic [3:0]  drop_off = '0;
  logic        locked_prev = 1'b0;
  logic [9:0]  prev_t = '0;
  logic [1:0]  hold_c = '0;
  logic [11:0] exp_q[$];

  h14rx_tmds_align_decode #(
    .LockCount(LC), .SearchTimeout(ST), .LossTimeout(LT)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst), .tmds_word(tmds_word),
    .data(data), .ctrl(ctrl), .de(de), .locked(locked),
    .bit_offset(bit_offset), .fsm_state(fsm_state)
  );

  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  function automatic int popc8(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  // Transmit-side DVI/HDMI encoder with running disparity.
  function automatic logic [9:0] tmds_enc(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] q;
    int n1d, n1q, n0q;
    n1d = popc8(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = popc8(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8] == 1'b0) enc_cnt += n0q - n1q;
      else enc_cnt += n1q - n0q;
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += -(qm[8] ? 0 : 2) + n1q - n0q;
    end
    return q;
  endfunction

  task automatic clear_model();
    cyc = 0;
    lock_cyc = -1;
    drop_cyc = -1;
    locked_prev = 1'b0;
    hold_c = '0;
    enc_cnt = 0;
    exp_q.delete();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge pixel_clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  // Rotation delays the serial stream by rot bits relative to word boundaries.
  task automatic drive_word(input logic [9:0] t, input logic [10:0] e, input bit chk);
    logic [19:0] cat;
    logic [11:0] ent;
    cat = {t, prev_t};
    tmds_word = cat[10-rot +: 10];
    prev_t = t;
    exp_q.push_back({chk, e});
    @(posedge pixel_clk);
    #1;
    cyc++;
    if (locked && !locked_prev) lock_cyc = cyc;
    if (!locked && locked_prev) begin
      drop_cyc = cyc;
      drop_off = bit_offset;
    end
    locked_prev = locked;
    if (exp_q.size() > 2) begin
      ent = exp_q.pop_front();
      if (ent[11]) begin
        checks++;
        if ({de, ctrl, data} !== ent[10:0]) begin
          errors++;
          $display("FAIL sb_out cycle %0d: got {de,ctrl,data}=%h expected %h", cyc, {de, ctrl, data}, ent[10:0]);
        end
      end
    end
  endtask

  task automatic send_tok(input logic [1:0] c, input bit chk);
    enc_cnt = 0;
    hold_c = c;
    drive_word(ctrl_token(c), {1'b0, c, 8'h00}, chk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit chk);
    drive_word(tmds_enc(b), {1'b1, hold_c, b}, chk);
  endtask

  task automatic send_raw(input logic [9:0] w, input logic [7:0] b, input bit chk);
    drive_word(w, {1'b1, hold_c, b}, chk);
  endtask

  task automatic send_line(input int y, input bit vbl, input bit chk);
    for (int px = 0; px < LINE; px++) begin
      if (vbl || px < HBL) send_tok({vbl, (px >= 8 && px < 24)}, chk);
      else send_byte(8'((px - HBL) * 3 + y * 17), chk);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
    checks++; if (ctrl !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b expected 00", ctrl); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b expected 0", de); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (bit_offset !== 4'd0) begin errors++; $display("FAIL reset_offset: got %0d expected 0", bit_offset); end
    checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", fsm_state); end
  endtask

  task automatic test_lock();
    rot = 3;
    reset_dut();
    for (int l = 0; l < 8 && lock_cyc < 0; l++) send_line(l, 1'b0, 1'b0);
    checks++;
    if (lock_cyc < 0 || lock_cyc > 3 * ST + LINE + LC + 4) begin
      errors++; $display("FAIL lock_time: got cycle %0d expected <= %0d", lock_cyc, 3 * ST + LINE + LC + 4);
    end
    checks++; if (bit_offset !== 4'd3) begin errors++; $display("FAIL lock_offset: got %0d expected 3", bit_offset); end
    for (int l = 0; l < 2; l++) send_line(l, 1'b0, 1'b1);
  endtask

  task automatic test_decode();
    repeat (3) send_tok(2'b00, 1'b1);
    send_raw(10'h100, 8'h00, 1'b1);
    send_raw(10'h1FF, 8'h01, 1'b1);
    send_raw(10'h3FF, 8'h00, 1'b1);
    send_tok(2'b01, 1'b1);
    send_raw(10'h100, 8'h00, 1'b1);
    send_tok(2'b10, 1'b1);
    send_tok(2'b11, 1'b1);
    send_raw(10'h3FF, 8'h00, 1'b1);
    send_tok(2'b00, 1'b1);
    repeat (64) send_byte(8'($urandom_range(0, 255)), 1'b1);
    repeat (4) send_tok(2'b00, 1'b1);
  endtask

  task automatic test_reset_pulse();
    repeat (3) send_raw(10'h1FF, 8'h01, 1'b0);
    checks++;
    if (!(locked === 1'b1 && de === 1'b1 && data === 8'h01)) begin
      errors++; $display("FAIL pre_reset: got locked=%b de=%b data=%h expected 1 1 01", locked, de, data);
    end
    rst = 1'b1;
    @(posedge pixel_clk);
    #1;
    rst = 1'b0;
    clear_model();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL pulse_locked: got %b expected 0", locked); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL pulse_de: got %b expected 0", de); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL pulse_data: got %h expected 00", data); end
    checks++; if (bit_offset !== 4'd0) begin errors++; $display("FAIL pulse_offset: got %0d expected 0", bit_offset); end
  endtask

  task automatic test_slip();
    bit lock_seen = 1'b0;
    logic [3:0] exp_off;
    rot = 5;
    reset_dut();
    for (int n = 0; n < 10 * ST + 4; n++) begin
      if (n % 12 == 11) send_raw(10'h1FF, 8'h01, 1'b0);
      else send_tok(2'b00, 1'b0);
      if (locked) lock_seen = 1'b1;
      if ((cyc % ST == ST - 1) || (cyc % ST == 0)) begin
        exp_off = 4'((cyc / ST) % 10);
        checks++;
        if (bit_offset !== exp_off) begin
          errors++; $display("FAIL slip_offset cycle %0d: got %0d expected %0d", cyc, bit_offset, exp_off);
        end
      end
    end
    checks++; if (lock_seen) begin errors++; $display("FAIL slip_nolock: got locked=1 expected 0"); end
  endtask

  task automatic test_loss_relock();
    int c0;
    rot = 9;
    reset_dut();
    for (int n = 0; n < 10 * ST + LC + 8 && lock_cyc < 0; n++) send_tok(2'b00, 1'b0);
    checks++;
    if (lock_cyc < 9 * ST + LC - 1 || lock_cyc > 9 * ST + LC + 1) begin
      errors++; $display("FAIL hunt_lock_time: got %0d expected about %0d", lock_cyc, 9 * ST + LC);
    end
    checks++; if (bit_offset !== 4'd9) begin errors++; $display("FAIL hunt_offset: got %0d expected 9", bit_offset); end
    rot = 0;
    c0 = cyc;
    lock_cyc = -1;
    drop_cyc = -1;
    for (int n = 0; n < LT + LC + 40 && !(drop_cyc >= 0 && lock_cyc >= 0); n++) send_tok(2'b00, 1'b0);
    checks++;
    if (drop_cyc < c0 + LT - 1 || drop_cyc > c0 + LT + 3) begin
      errors++; $display("FAIL loss_time: got %0d expected about %0d", drop_cyc, c0 + LT + 1);
    end
    checks++; if (drop_off !== 4'd0) begin errors++; $display("FAIL loss_wrap: got %0d expected 0", drop_off); end
    checks++;
    if (drop_cyc < 0 || lock_cyc < drop_cyc + LC - 1 || lock_cyc > drop_cyc + LC + 1) begin
      errors++; $display("FAIL relock_time: got %0d expected about %0d", lock_cyc, drop_cyc + LC);
    end
    checks++; if (bit_offset !== 4'd0) begin errors++; $display("FAIL relock_offset: got %0d expected 0", bit_offset); end
  endtask

  task automatic test_frames();
    int ln = 0;
    rot = 7;
    reset_dut();
    while (ln < 25 && (lock_cyc < 0 || ln % 5 != 0)) begin
      send_line(ln % 5, (ln % 5) < 2, 1'b0);
      ln++;
    end
    checks++; if (lock_cyc < 0) begin errors++; $display("FAIL frame_lock: got unlocked expected locked"); end
    for (int f = 0; f < 3; f++) begin
      for (int y = 0; y < 5; y++) send_line(y, y < 2, 1'b1);
    end
    send_tok(2'b00, 1'b0);
    send_tok(2'b00, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL frame_hold: got locked=%b expected 1", locked); end
    checks++; if (bit_offset !== 4'd7) begin errors++; $display("FAIL frame_offset: got %0d expected 7", bit_offset); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_decode();
    test_reset_pulse();
    test_slip();
    test_loss_relock();
    test_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
